// File: rtl/mdu_pkg.sv
// Shared types and constants for the mul/div issue controller.
package mdu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_HOLD,
        ST_DRAIN
    } mdu_state_e;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    localparam int MUL_LAT_DEF = 10;
    localparam int DIV_LAT_DEF = 40;
    localparam int SLACK_DEF   = 4;

    // Wide enough for DIV_LAT + SLACK with headroom.
    localparam int WD_W = 8;

    function automatic logic [WD_W-1:0] wd_init(input logic op, input int mul_lat,
                                                input int div_lat, input int slack);
        return (op == OP_DIV) ? WD_W'(div_lat + slack) : WD_W'(mul_lat + slack);
    endfunction

endpackage

// File: rtl/mdu_issue_if.sv
// Decode, execute-unit and writeback signals of the mul/div issue controller.
interface mdu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic            in_op;
    logic [XLEN-1:0] in_a;
    logic [XLEN-1:0] in_b;
    logic [4:0]      in_rd;
    logic            flush;
    logic            mdu_start;
    logic            mdu_op;
    logic [XLEN-1:0] mdu_a;
    logic [XLEN-1:0] mdu_b;
    logic            mdu_valid;
    logic [XLEN-1:0] mdu_result;
    logic            wb_valid;
    logic            wb_ready;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            busy;
    logic [4:0]      busy_rd;
    logic            timeout_err;

    modport master (
        output in_valid, in_op, in_a, in_b, in_rd, flush, mdu_valid, mdu_result, wb_ready,
        input  in_ready, mdu_start, mdu_op, mdu_a, mdu_b, wb_valid, wb_rd, wb_data,
               busy, busy_rd, timeout_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_rd, flush, mdu_valid, mdu_result, wb_ready,
        output in_ready, mdu_start, mdu_op, mdu_a, mdu_b, wb_valid, wb_rd, wb_data,
               busy, busy_rd, timeout_err
    );
endinterface

// File: rtl/mdu_watchdog.sv
// Down-counting watchdog: load, decrement, expire on the last decrement.
module mdu_watchdog
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [WD_W-1:0] load_val,
    input  logic            dec,
    output logic            expire
);
    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Fires on the cycle whose decrement takes the count to zero.
    assign expire = dec && (cnt_q <= WD_W'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mdu_issue.sv
// Issue/writeback controller for the multi-cycle mul/div unit.
// Optional MDU_DIVZERO_EN: divide by zero bypasses the unit and returns all ones.
module mdu_issue
    import mdu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int SLACK   = SLACK_DEF
) (
    input logic         clk,
    input logic         rst_n,
    mdu_issue_if.slave  bus
);
    mdu_state_e      state_q, state_d;
    logic            op_q, op_d;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, wb_data_q, wb_data_d;
    logic [4:0]      rd_q, rd_d, busy_rd_q, busy_rd_d;
    logic            timeout_q, timeout_d;
    logic            mdu_start_q, mdu_start_d;
    logic            wb_valid_q, wb_valid_d;
    logic            busy_q, busy_d;
    logic            in_ready, accept, divzero;
    logic            wd_load, wd_dec, wd_expire;

    assign in_ready = rst_n & ~bus.flush &
                      ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.wb_ready));
    assign accept   = bus.in_valid & in_ready;

    mdu_watchdog u_wd (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wd_load),
        .load_val (wd_init(op_q, MUL_LAT, DIV_LAT, SLACK)),
        .dec      (wd_dec),
        .expire   (wd_expire)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        wb_data_d = wb_data_q;
        timeout_d = timeout_q;
        wd_load   = 1'b0;
        wd_dec    = 1'b0;
        divzero   = 1'b0;
`ifdef MDU_DIVZERO_EN
        divzero   = (bus.in_op == OP_DIV) && (bus.in_b == '0);
`endif
        case (state_q)
            ST_IDLE: ;
            ST_LAUNCH: begin
                wd_load = 1'b1;
                state_d = bus.flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                wd_dec = 1'b1;
                // A flush that coincides with completion has nothing left to drain.
                if (bus.flush) begin
                    state_d = (bus.mdu_valid || wd_expire) ? ST_IDLE : ST_DRAIN;
                end else if (bus.mdu_valid) begin
                    wb_data_d = bus.mdu_result;
                    state_d   = ST_HOLD;
                end else if (wd_expire) begin
                    wb_data_d = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                wd_dec = 1'b1;
                if (bus.mdu_valid || wd_expire) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.flush || bus.wb_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            op_d = bus.in_op;
            a_d  = bus.in_a;
            b_d  = bus.in_b;
            rd_d = bus.in_rd;
            if (divzero) begin
                wb_data_d = '1;
                state_d   = ST_HOLD;
            end else begin
                state_d   = ST_LAUNCH;
            end
        end

        mdu_start_d = (state_d == ST_LAUNCH);
        wb_valid_d  = (state_d == ST_HOLD);
        busy_d      = (state_d != ST_IDLE);
        busy_rd_d   = busy_d ? rd_d : 5'd0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
            mdu_start_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            busy_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rd_q        <= rd_d;
            wb_data_q   <= wb_data_d;
            timeout_q   <= timeout_d;
            mdu_start_q <= mdu_start_d;
            wb_valid_q  <= wb_valid_d;
            busy_q      <= busy_d;
            busy_rd_q   <= busy_rd_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mdu_start   = mdu_start_q;
    assign bus.mdu_op      = op_q;
    assign bus.mdu_a       = a_q;
    assign bus.mdu_b       = b_q;
    assign bus.wb_valid    = wb_valid_q;
    assign bus.wb_rd       = rd_q;
    assign bus.wb_data     = wb_data_q;
    assign bus.busy        = busy_q;
    assign bus.busy_rd     = busy_rd_q;
    assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_mdu_issue.sv
// Bench for mdu_issue: directed scenarios plus random traffic against a transaction-level model.
module tb_mdu_issue;
    localparam int MUL_LAT = 10;
    localparam int DIV_LAT = 40;
    localparam int SLACK   = 4;
`ifdef MDU_DIVZERO_EN
    localparam bit DZ = 1'b1;
`else
    localparam bit DZ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_issue_if #(.XLEN(32)) bus ();
    mdu_issue #(.XLEN(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .SLACK(SLACK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        if (op) return (b == 0) ? 32'hFFFF_FFFF : a / b;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    // Model: flags for where the held operation is, absolute-cycle deadline for the watchdog.
    bit          m_busy, m_start_due, m_wait, m_drain, m_wb, m_tmo;
    logic        m_op;
    logic [31:0] m_a, m_b, m_res, m_wb_data;
    logic [4:0]  m_rd;
    int unsigned cyc = 0;
    int unsigned m_deadline;

    function automatic bit exp_in_ready();
        return rst_n && !bus.flush && (!m_busy || (m_wb && bus.wb_ready));
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = bus.in_valid && exp_in_ready();
        if (!rst_n) begin
            m_start_due = 0; m_wait = 0; m_drain = 0; m_wb = 0; m_tmo = 0;
            m_rd = 0; m_op = 0; m_a = 0; m_b = 0;
        end else begin
            if (m_start_due) begin
                m_start_due = 0;
                m_deadline  = cyc + (m_op ? DIV_LAT : MUL_LAT) + SLACK;
                if (bus.flush) m_drain = 1; else m_wait = 1;
            end else if (m_wait) begin
                m_wait = 0;
                if (bus.flush) m_drain = !(bus.mdu_valid || cyc == m_deadline);
                else if (bus.mdu_valid) begin m_wb = 1; m_wb_data = m_res; end
                else if (cyc == m_deadline) begin m_wb = 1; m_wb_data = 0; m_tmo = 1; end
                else m_wait = 1;
            end else if (m_drain) begin
                if (bus.mdu_valid || cyc == m_deadline) m_drain = 0;
            end else if (m_wb) begin
                if (bus.flush || bus.wb_ready) m_wb = 0;
            end
            if (acc) begin
                m_op = bus.in_op; m_a = bus.in_a; m_b = bus.in_b; m_rd = bus.in_rd;
                m_res = ref_result(m_op, m_a, m_b);
                if (DZ && m_op && m_b == 0) begin m_wb = 1; m_wb_data = '1; end
                else m_start_due = 1;
            end
        end
        m_busy = m_start_due || m_wait || m_drain || m_wb;
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("in_ready", bus.in_ready, exp_in_ready());
            cmp("mdu_start", bus.mdu_start, m_start_due);
            cmp("wb_valid", bus.wb_valid, m_wb);
            cmp("busy", bus.busy, m_busy);
            cmp("busy_rd", bus.busy_rd, m_busy ? m_rd : 5'd0);
            cmp("timeout_err", bus.timeout_err, m_tmo);
            if (m_wb) begin
                cmp("wb_data", bus.wb_data, m_wb_data);
                cmp("wb_rd", bus.wb_rd, m_rd);
            end
            if (m_start_due || m_wait || m_drain) begin
                cmp("mdu_op", bus.mdu_op, m_op);
                cmp("mdu_a", bus.mdu_a, m_a);
                cmp("mdu_b", bus.mdu_b, m_b);
            end
        end
    end

    // Execute-unit stand-in; latency <= 0 means it never answers.
    bit          u_active, u_rand;
    int          u_cnt, u_lat;
    int unsigned u_valid_cyc;
    logic        u_op;
    logic [31:0] u_a, u_b;

    task automatic tick();
        int lat;
        @(posedge clk);
        #1;
        bus.mdu_valid = 1'b0;
        if (u_active) begin
            u_cnt--;
            if (u_cnt == 0) begin
                u_active = 0;
                bus.mdu_valid  = 1'b1;
                bus.mdu_result = ref_result(u_op, u_a, u_b);
                u_valid_cyc    = cyc;
            end
        end else if (u_rand && !(m_start_due || m_wait || m_drain) && $urandom_range(0, 19) == 0) begin
            bus.mdu_valid  = 1'b1;
            bus.mdu_result = $urandom;
        end
        if (bus.mdu_start) begin
            u_op = bus.mdu_op; u_a = bus.mdu_a; u_b = bus.mdu_b;
            if (u_rand) begin
                lat = ($urandom_range(0, 19) == 0) ? 0 :
                      $urandom_range(1, (u_op ? DIV_LAT : MUL_LAT) + SLACK);
            end else begin
                lat = u_lat;
            end
            u_active = (lat > 0);
            u_cnt    = lat;
        end
    endtask

    task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.in_valid = 1; bus.in_op = op; bus.in_a = a; bus.in_b = b; bus.in_rd = rd;
        #0;
        for (int i = 0; i < 200 && !bus.in_ready; i++) tick();
        cmp("issue_wait", bus.in_ready, 1);
        tick();
        bus.in_valid = 0;
    endtask

    task automatic wait_wb(output int n);
        n = 0;
        while (!bus.wb_valid && n < 100) begin tick(); n++; end
        cmp("wb_wait", bus.wb_valid, 1);
    endtask

    initial begin
        int n;
        bit saw_wb;
        bus.in_valid = 0; bus.in_op = 0; bus.in_a = 0; bus.in_b = 0; bus.in_rd = 0;
        bus.flush = 0; bus.mdu_valid = 0; bus.mdu_result = 0; bus.wb_ready = 1;
        u_active = 0; u_rand = 0; u_lat = 10; u_cnt = 0;

        tick();
        chk_en = 1;
        tick(); tick();
        cmp("reset_in_ready", bus.in_ready, 0);
        rst_n = 1;
        #0;
        cmp("ready_after_reset", bus.in_ready, 1);

        // 7 x 6, unit answers 10 cycles after start
        bus.wb_ready = 1; u_lat = 10;
        issue(0, 7, 6, 5'd3);
        cmp("mul_start", bus.mdu_start, 1);
        wait_wb(n);
        cmp("mul_latency", n, 11);
        cmp("mul_data", bus.wb_data, 42);
        tick();
        cmp("mul_idle", bus.busy, 0);

        // 100 / 7 with writeback stalled 5 cycles
        bus.wb_ready = 0; u_lat = 40;
        issue(1, 100, 7, 5'd9);
        wait_wb(n);
        for (int i = 0; i < 5; i++) begin
            cmp("div_hold_data", bus.wb_data, 14);
            cmp("div_hold_rd", bus.wb_rd, 9);
            cmp("div_hold_ready", bus.in_ready, 0);
            tick();
        end
        bus.wb_ready = 1;
        tick();

        // back-to-back: retire and accept on the same edge
        bus.wb_ready = 0; u_lat = 2;
        issue(0, 3, 5, 5'd3);
        wait_wb(n);
        cmp("b2b_first", bus.wb_data, 15);
        bus.wb_ready = 1;
        bus.in_valid = 1; bus.in_op = 0; bus.in_a = 9; bus.in_b = 9; bus.in_rd = 5'd4;
        #1;
        cmp("b2b_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 0;
        cmp("b2b_start", bus.mdu_start, 1);
        cmp("b2b_busy_rd", bus.busy_rd, 4);
        wait_wb(n);
        cmp("b2b_second", bus.wb_data, 81);
        tick();

        // flush three cycles into a divide
        u_lat = 20;
        issue(1, 50, 5, 5'd7);
        tick(); tick(); tick();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        saw_wb = 0;
        n = 0;
        while (!bus.in_ready && n < 100) begin saw_wb |= bus.wb_valid; tick(); n++; end
        cmp("flush_ready", bus.in_ready, 1);
        cmp("flush_ready_cycle", cyc, u_valid_cyc + 1);
        cmp("flush_no_wb", saw_wb, 0);

        // multiply that never completes
        u_lat = 0;
        issue(0, 11, 12, 5'd1);
        wait_wb(n);
        cmp("tmo_cycles", n, 15);
        cmp("tmo_flag", bus.timeout_err, 1);
        cmp("tmo_data", bus.wb_data, 0);
        tick();

        // divide by zero
`ifdef MDU_DIVZERO_EN
        issue(1, 5, 0, 5'd2);
        cmp("dz_no_start", bus.mdu_start, 0);
        cmp("dz_hold", bus.wb_valid, 1);
        cmp("dz_data", bus.wb_data, 32'hFFFF_FFFF);
        tick();
`else
        u_lat = 3;
        issue(1, 5, 0, 5'd2);
        cmp("dz_start", bus.mdu_start, 1);
        wait_wb(n);
        cmp("dz_data", bus.wb_data, 32'hFFFF_FFFF);
        tick();
`endif

        // reset mid-operation; the late unit answer must be ignored
        u_lat = 30;
        issue(1, 8, 2, 5'd6);
        repeat (5) tick();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        #0;
        cmp("rst_mid_busy", bus.busy, 0);
        cmp("rst_mid_tmo", bus.timeout_err, 0);
        repeat (40) tick();
        cmp("rst_stale_busy", bus.busy, 0);

        // random traffic
        u_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_op    = 1'($urandom_range(0, 1));
            bus.in_a     = $urandom;
            bus.in_b     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            bus.in_rd    = 5'($urandom_range(0, 31));
            bus.wb_ready = ($urandom_range(0, 9) < 7);
            bus.flush    = ($urandom_range(0, 39) == 0);
            tick();
        end
        bus.in_valid = 0; bus.flush = 0; bus.wb_ready = 1;
        repeat (60) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "simulation did not terminate");
    end
endmodule
